// File: rtl/ternary_pack_stream_if.sv
// ternary_pack_stream_if: accumulator value stream in, packed-trit word stream out
interface ternary_pack_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int THR_WIDTH = 16,
  parameter int OUT_BYTES = 1
);
  localparam int N = 5 * OUT_BYTES;
  localparam int CW = $clog2(N + 1);
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [DATA_WIDTH-1:0] in_data;
  logic [THR_WIDTH-1:0] thr_lo, thr_hi;
  logic [8*OUT_BYTES-1:0] out_data;
  logic [CW-1:0] out_count;
  modport master(
    output in_valid, in_data, in_last, thr_lo, thr_hi, out_ready,
    input in_ready, out_valid, out_data, out_last, out_count
  );
  modport slave(
    input in_valid, in_data, in_last, thr_lo, thr_hi, out_ready,
    output in_ready, out_valid, out_data, out_last, out_count
  );
endinterface

// File: rtl/ternary_pack_stream.sv
// ternary_pack_stream: thresholds signed values to trits and packs 5 trits per byte.
// Optional per-class trit counters are built when TERNARY_PACK_STATS_EN is defined.
module ternary_pack_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int THR_WIDTH = 16,
  parameter int OUT_BYTES = 1
) (
  input logic clk_i,
  input logic rst_ni,
  ternary_pack_stream_if.slave s
`ifdef TERNARY_PACK_STATS_EN
  ,
  input logic stat_clr_i,
  output logic [31:0] stat_neg_o,
  output logic [31:0] stat_zero_o,
  output logic [31:0] stat_pos_o
`endif
);
  localparam int N = 5 * OUT_BYTES;
  localparam int CW = $clog2(N + 1);
  logic signed [DATA_WIDTH-1:0] data_s, lo_s, hi_s;
  logic [1:0] trit;
  logic [N-1:0][1:0] pack_q, pack_d;
  logic [CW-1:0] cnt_q;
  logic pack_full, last_q, accept, complete, out_free;
  assign data_s = s.in_data;
  assign lo_s = DATA_WIDTH'($signed(s.thr_lo));
  assign hi_s = DATA_WIDTH'($signed(s.thr_hi));
  // trit code: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1, so a cleared slot reads as 0
  assign trit = data_s < lo_s ? 2'b11 : data_s >= hi_s ? 2'b01 : 2'b00;
  assign s.in_ready = !pack_full;
  assign accept = s.in_valid && !pack_full;
  assign complete = accept && (s.in_last || cnt_q == CW'(N - 1));
  assign out_free = !s.out_valid || s.out_ready;
  function automatic logic [8*OUT_BYTES-1:0] encode(input logic [N-1:0][1:0] t);
    logic [7:0] acc;
    encode = '0;
    for (int b = 0; b < OUT_BYTES; b++) begin
      acc = 8'd0;
      for (int j = 4; j >= 0; j--)
        acc = acc * 8'd3 + (t[5*b+j] == 2'b01 ? 8'd2 : t[5*b+j] == 2'b00 ? 8'd1 : 8'd0);
      encode[8*b+:8] = acc;
    end
  endfunction
  // current word with the incoming trit dropped into its slot
  always_comb begin
    pack_d = pack_q;
    pack_d[cnt_q] = trit;
  end
  // pack buffer, slot counter and one-word output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pack_q <= '0;
      cnt_q <= '0;
      pack_full <= 1'b0;
      last_q <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_data <= '0;
      s.out_last <= 1'b0;
      s.out_count <= '0;
    end else if (pack_full && out_free) begin
      s.out_valid <= 1'b1;
      s.out_data <= encode(pack_q);
      s.out_last <= last_q;
      s.out_count <= cnt_q + 1'b1;
      pack_q <= '0;
      cnt_q <= '0;
      pack_full <= 1'b0;
    end else if (complete && out_free) begin
      s.out_valid <= 1'b1;
      s.out_data <= encode(pack_d);
      s.out_last <= s.in_last;
      s.out_count <= cnt_q + 1'b1;
      pack_q <= '0;
      cnt_q <= '0;
    end else begin
      if (s.out_ready) s.out_valid <= 1'b0;
      if (complete) begin
        pack_q <= pack_d;
        pack_full <= 1'b1;
        last_q <= s.in_last;
      end else if (accept) begin
        pack_q <= pack_d;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`ifdef TERNARY_PACK_STATS_EN
  // clear-then-count trit class counters; padding trits never pass through here
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_neg_o <= '0;
      stat_zero_o <= '0;
      stat_pos_o <= '0;
    end else begin
      stat_neg_o <= (stat_clr_i ? 32'd0 : stat_neg_o) + 32'(accept && trit == 2'b11);
      stat_zero_o <= (stat_clr_i ? 32'd0 : stat_zero_o) + 32'(accept && trit == 2'b00);
      stat_pos_o <= (stat_clr_i ? 32'd0 : stat_pos_o) + 32'(accept && trit == 2'b01);
    end
  end
`endif
endmodule
